// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO pointer/flag controller.
package fifo_ctrl_pkg;

  localparam int unsigned DEPTH_DEF           = 256;
  localparam int unsigned DATA_W_DEF          = 8;
  localparam int unsigned ALMOST_FULL_TH_DEF  = 240;
  localparam int unsigned ALMOST_EMPTY_TH_DEF = 16;

  // Controller occupancy state; S_FLUSH is the one-cycle settle after reset/flush.
  typedef enum logic [1:0] {
    S_FLUSH   = 2'd0,
    S_EMPTY   = 2'd1,
    S_PARTIAL = 2'd2,
    S_FULL    = 2'd3
  } fifo_state_e;

endpackage

// File: rtl/fifo_ptr_gen.sv
// Wrap-bit pointer counter: increments on inc_i, synchronously clears on clr_i.
module fifo_ptr_gen
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned PTR_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  // Next pointer value; clear wins over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: flow-controlled write/read pointers, occupancy,
// full/empty, sticky overflow/underflow and memory strobe decode.
// Optional build macro FIFO_CTRL_ALMOST_FLAGS_EN adds registered almost_full /
// almost_empty outputs driven from the ALMOST_* thresholds.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH           = DEPTH_DEF,
  parameter int unsigned ADDR_W          = $clog2(DEPTH),
  parameter int unsigned DATA_W          = DATA_W_DEF
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  parameter int unsigned ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
  parameter int unsigned ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  fifo_state_e      state_q;
  fifo_state_e      state_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] occ;
  logic             wr_fire;
  logic             rd_fire;
  logic             rd_allowed;
  logic             overflow_q;
  logic             overflow_d;
  logic             underflow_q;
  logic             underflow_d;
  logic             rd_valid_q;

  // Occupancy is the wrap-aware pointer difference.
  assign occ = wr_ptr - rd_ptr;

  // Handshake decode; flush blocks both sides in the same cycle.
  always_comb begin
    wr_ready   = 1'b0;
    rd_allowed = 1'b0;
    if (!flush) begin
      wr_ready   = (state_q == S_EMPTY) || (state_q == S_PARTIAL);
      rd_allowed = (state_q == S_PARTIAL) || (state_q == S_FULL);
    end
    wr_fire = wr_valid && wr_ready;
    rd_fire = rd_req && rd_allowed;
  end

  fifo_ptr_gen #(
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_fire),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_gen #(
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_fire),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FLUSH: begin
        state_d = S_EMPTY;
      end
      S_EMPTY: begin
        if (wr_fire) begin
          state_d = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (wr_fire && !rd_fire && (occ == PTR_W'(DEPTH - 1))) begin
          state_d = S_FULL;
        end else if (rd_fire && !wr_fire && (occ == PTR_W'(1))) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (rd_fire) begin
          state_d = S_PARTIAL;
        end
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase
    if (flush) begin
      state_d = S_FLUSH;
    end
  end

  // Sticky error flags; only flush (or reset) clears them.
  always_comb begin
    overflow_d  = overflow_q  || (wr_valid && (state_q == S_FULL));
    underflow_d = underflow_q || (rd_req && (state_q == S_EMPTY));
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // State, error and read-valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FLUSH;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_fire;
    end
  end

  assign mem_wr_en   = {DATA_W{wr_fire}};
  assign mem_rd_en   = rd_fire;
  assign mem_wr_addr = wr_ptr[ADDR_W-1:0];
  assign mem_rd_addr = rd_ptr[ADDR_W-1:0];
  assign count       = occ;
  assign full        = (occ == PTR_W'(DEPTH));
  assign empty       = (occ == '0);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign rd_valid    = rd_valid_q;

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  logic [PTR_W-1:0] occ_d;
  logic             almost_full_q;
  logic             almost_full_d;
  logic             almost_empty_q;
  logic             almost_empty_d;

  // Threshold flags computed from next-cycle occupancy so they track count.
  always_comb begin
    occ_d          = occ + PTR_W'(wr_fire) - PTR_W'(rd_fire);
    almost_full_d  = (occ_d >= PTR_W'(ALMOST_FULL_TH));
    almost_empty_d = (occ_d <= PTR_W'(ALMOST_EMPTY_TH));
    if (state_d == S_FLUSH) begin
      occ_d          = '0;
      almost_full_d  = 1'b0;
      almost_empty_d = 1'b1;
    end
  end

  // Almost-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
